// File: rtl/sw_event_counter_pkg.sv
// Shared constants for the switch event counter: key bit positions and
// the active-low seven-segment glyph table.
package sw_event_counter_pkg;

   localparam int KEY_DIR  = 0;
   localparam int KEY_CAP  = 1;
   localparam int KEY_CLR  = 2;
   localparam int NUM_KEYS = 3;

   // Segment order is bit0=a .. bit6=g; a 0 lights the segment.
   localparam logic [6:0] SEG_TABLE [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

endpackage

// File: rtl/sw_event_counter_key_sync_edge.sv
// Per-bit synchronizer for active-low buttons, followed by a falling-edge
// detector that emits a one-cycle press pulse.
module key_sync_edge #(
   parameter int W           = 3,
   parameter int SYNC_STAGES = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] key_n,
   output logic [W-1:0] press
);

   logic [W-1:0] sync [SYNC_STAGES];
   logic [W-1:0] prev;

   // Reset to released (1) so a key held through reset still yields one press.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            sync[s] <= '1;
         end
         prev <= '1;
      end else begin
         sync[0] <= key_n;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            sync[s] <= sync[s-1];
         end
         prev <= sync[SYNC_STAGES-1];
      end
   end

   assign press = prev & ~sync[SYNC_STAGES-1];

endmodule

// File: rtl/sw_event_counter.sv
// Button-driven event counter: captures switches, counts up or down with
// wrap or saturation, and shows count and captured value on hex digits.
module sw_event_counter #(
   parameter int SW_W        = 10,
   parameter int CNT_W       = 8,
   parameter int DIGITS      = 4,
   parameter int SYNC_STAGES = 2,
   parameter int SATURATE    = 0
) (
   input  logic                clk100_i,
   input  logic                rst_i,
   input  logic [SW_W-1:0]     sw_i,
   input  logic [2:0]          key_i,
   output logic [SW_W-1:0]     ledr_o,
   output logic [CNT_W-1:0]    cnt_o,
   output logic                ovf_o,
   output logic [7*DIGITS-1:0] hex_o
);

   import sw_event_counter_pkg::*;

   localparam int HALF = DIGITS / 2;
   localparam int HW   = 4 * HALF;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [NUM_KEYS-1:0] press;
   logic [CNT_W-1:0]    count, count_next;
   logic [SW_W-1:0]     ledr, ledr_next;
   logic                ovf, ovf_next;
   logic                dir_down, dir_next;
   logic [2*HW-1:0]     disp;
   logic [7*DIGITS-1:0] hex, hex_next;

   key_sync_edge #(
      .W           (NUM_KEYS),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_keys (
      .clk   (clk100_i),
      .rst   (rst_i),
      .key_n (key_i),
      .press (press)
   );

   // Clear outranks capture; a capture in the toggle cycle uses the old direction.
   always_comb begin
      count_next = count;
      ledr_next  = ledr;
      ovf_next   = ovf;
      dir_next   = dir_down ^ press[KEY_DIR];
      if (press[KEY_CLR]) begin
         count_next = '0;
         ledr_next  = '0;
         ovf_next   = 1'b0;
      end else if (press[KEY_CAP]) begin
         ledr_next = sw_i;
         if (!dir_down) begin
            if (count == CNT_MAX) begin
               ovf_next   = 1'b1;
               count_next = (SATURATE != 0) ? CNT_MAX : '0;
            end else begin
               count_next = count + CNT_W'(1);
            end
         end else begin
            if (count == '0) begin
               ovf_next   = 1'b1;
               count_next = (SATURATE != 0) ? '0 : CNT_MAX;
            end else begin
               count_next = count - CNT_W'(1);
            end
         end
      end else begin
         count_next = count;
      end
   end

   genvar b;
   for (b = 0; b < HW; b++) begin : g_disp
      if (b < CNT_W) begin : g_cnt
         assign disp[HW+b] = count[b];
      end else begin : g_cnt_pad
         assign disp[HW+b] = 1'b0;
      end
      if (b < SW_W) begin : g_sw
         assign disp[b] = ledr[b];
      end else begin : g_sw_pad
         assign disp[b] = 1'b0;
      end
   end

   always_comb begin
      hex_next = '0;
      for (int d = 0; d < DIGITS; d++) begin
         hex_next[7*d +: 7] = SEG_TABLE[disp[4*d +: 4]];
      end
   end

   always_ff @(posedge clk100_i or posedge rst_i) begin
      if (rst_i) begin
         count    <= '0;
         ledr     <= '0;
         ovf      <= 1'b0;
         dir_down <= 1'b0;
         hex      <= {DIGITS{SEG_TABLE[0]}};
      end else begin
         count    <= count_next;
         ledr     <= ledr_next;
         ovf      <= ovf_next;
         dir_down <= dir_next;
         hex      <= hex_next;
      end
   end

   assign cnt_o  = count;
   assign ledr_o = ledr;
   assign ovf_o  = ovf;
   assign hex_o  = hex;

endmodule

// File: tb/tb_sw_event_counter.sv
// Bench for sw_event_counter: wrap and saturate instances driven in parallel,
// checked every cycle against an arithmetic model plus pinned literals.
module tb_sw_event_counter;

   localparam int S = 2;

   localparam logic [6:0] GLYPH [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [9:0]  sw  = '0;
   logic [2:0]  key = 3'b111;

   logic [9:0]  ledr_d [2];
   logic [7:0]  cnt_d  [2];
   logic        ovf_d  [2];
   logic [27:0] hex_d  [2];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sw_event_counter #(.SW_W(10), .CNT_W(8), .DIGITS(4), .SYNC_STAGES(S), .SATURATE(0)) u_wrap (
      .clk100_i (clk), .rst_i (rst), .sw_i (sw), .key_i (key),
      .ledr_o (ledr_d[0]), .cnt_o (cnt_d[0]), .ovf_o (ovf_d[0]), .hex_o (hex_d[0])
   );

   sw_event_counter #(.SW_W(10), .CNT_W(8), .DIGITS(4), .SYNC_STAGES(S), .SATURATE(1)) u_sat (
      .clk100_i (clk), .rst_i (rst), .sw_i (sw), .key_i (key),
      .ledr_o (ledr_d[1]), .cnt_o (cnt_d[1]), .ovf_o (ovf_d[1]), .hex_o (hex_d[1])
   );

   // ---------------- behavioural model ----------------
   logic [2:0]  hist [S+1];   // hist[k] = key value seen k+1 edges ago
   int          m_cnt [2];
   logic [9:0]  m_ledr;
   bit          m_ovf [2];
   bit          m_down;
   logic [27:0] m_hex [2];

   function automatic logic [27:0] hex_of(int c, logic [9:0] l);
      logic [15:0] v;
      logic [27:0] h;
      v = {8'(c), l[7:0]};
      for (int d = 0; d < 4; d++) h[7*d +: 7] = GLYPH[v[4*d +: 4]];
      return h;
   endfunction

   function automatic bit blocked(int c, bit down);
      return down ? (c == 0) : (c == 255);
   endfunction

   function automatic int stepped(int c, bit down, bit sat);
      int n;
      n = down ? c - 1 : c + 1;
      if (sat) return (n < 0) ? 0 : ((n > 255) ? 255 : n);
      return (n + 256) % 256;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int j = 0; j <= S; j++) hist[j] <= 3'b111;
         for (int i = 0; i < 2; i++) begin
            m_cnt[i] <= 0;
            m_ovf[i] <= 1'b0;
            m_hex[i] <= {4{7'h40}};
         end
         m_ledr <= '0;
         m_down <= 1'b0;
      end else begin
         // a press is a key seen high S+1 edges ago and low S edges ago
         for (int i = 0; i < 2; i++) m_hex[i] <= hex_of(m_cnt[i], m_ledr);
         if (hist[S][2] && !hist[S-1][2]) begin
            for (int i = 0; i < 2; i++) begin
               m_cnt[i] <= 0;
               m_ovf[i] <= 1'b0;
            end
            m_ledr <= '0;
         end else if (hist[S][1] && !hist[S-1][1]) begin
            m_ledr <= sw;
            for (int i = 0; i < 2; i++) begin
               m_cnt[i] <= stepped(m_cnt[i], m_down, i == 1);
               if (blocked(m_cnt[i], m_down)) m_ovf[i] <= 1'b1;
            end
         end
         if (hist[S][0] && !hist[S-1][0]) m_down <= ~m_down;
         hist[0] <= key;
         for (int j = 1; j <= S; j++) hist[j] <= hist[j-1];
      end
   end

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // every-cycle comparison against the model
   always @(posedge clk) begin
      #1;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("model_cnt[%0d]", i),  64'(cnt_d[i]),  64'(m_cnt[i]));
         chk($sformatf("model_ledr[%0d]", i), 64'(ledr_d[i]), 64'(m_ledr));
         chk($sformatf("model_ovf[%0d]", i),  64'(ovf_d[i]),  64'(m_ovf[i]));
         chk($sformatf("model_hex[%0d]", i),  64'(hex_d[i]),  64'(m_hex[i]));
      end
   end

   task automatic cyc(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(int idx);
      key[idx] = 1'b0;
      cyc(2);
      key[idx] = 1'b1;
      cyc(2);
   endtask

   initial begin
      cyc(3);
      rst = 1'b0;
      cyc(2);

      // single capture press, key held low 10 cycles
      sw = 10'h2A5;
      key[1] = 1'b0;
      cyc(2);
      chk("cap_not_early", 64'(cnt_d[0]), 64'd0);
      cyc(1);
      chk("cap_cycle3", 64'(cnt_d[0]), 64'd1);
      chk("cap_ledr", 64'(ledr_d[0]), 64'h2A5);
      cyc(1);
      chk("cap_hex", 64'(hex_d[0]), 64'({7'h40, 7'h79, 7'h08, 7'h12}));
      cyc(6);
      key[1] = 1'b1;
      cyc(4);
      chk("cap_single", 64'(cnt_d[0]), 64'd1);

      // asynchronous reset mid-clock
      rst = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("rst_cnt", 64'(cnt_d[i]), 64'd0);
         chk("rst_ledr", 64'(ledr_d[i]), 64'd0);
         chk("rst_ovf", 64'(ovf_d[i]), 64'd0);
         chk("rst_hex", 64'(hex_d[i]), 64'({4{7'h40}}));
      end
      cyc(1);
      rst = 1'b0;
      cyc(2);

      // 256 and then 300 capture presses
      for (int n = 0; n < 256; n++) press(1);
      cyc(2);
      chk("wrap256_cnt", 64'(cnt_d[0]), 64'd0);
      chk("wrap256_ovf", 64'(ovf_d[0]), 64'd1);
      chk("sat256_cnt", 64'(cnt_d[1]), 64'd255);
      chk("sat256_ovf", 64'(ovf_d[1]), 64'd1);
      for (int n = 0; n < 44; n++) press(1);
      cyc(2);
      chk("wrap300_cnt", 64'(cnt_d[0]), 64'd44);
      chk("sat300_cnt", 64'(cnt_d[1]), 64'd255);
      chk("sat300_ovf", 64'(ovf_d[1]), 64'd1);

      // direction toggle, underflow, toggle back
      press(2);
      cyc(2);
      chk("clr_ovf", 64'(ovf_d[0]), 64'd0);
      press(0);
      press(1);
      cyc(2);
      chk("down_wrap_cnt", 64'(cnt_d[0]), 64'd255);
      chk("down_wrap_ovf", 64'(ovf_d[0]), 64'd1);
      chk("down_sat_cnt", 64'(cnt_d[1]), 64'd0);
      chk("down_sat_ovf", 64'(ovf_d[1]), 64'd1);
      press(0);
      press(1);
      cyc(2);
      chk("up_again_wrap", 64'(cnt_d[0]), 64'd0);
      chk("up_again_sat", 64'(cnt_d[1]), 64'd1);

      // simultaneous clear and capture
      for (int n = 0; n < 5; n++) press(1);
      cyc(2);
      chk("pre_clr_cnt", 64'(cnt_d[0]), 64'd5);
      key = 3'b001;
      cyc(2);
      key = 3'b111;
      cyc(3);
      chk("clr_win_cnt", 64'(cnt_d[0]), 64'd0);
      chk("clr_win_ledr", 64'(ledr_d[0]), 64'd0);
      chk("clr_win_ovf", 64'(ovf_d[0]), 64'd0);
      chk("clr_win_sat", 64'(cnt_d[1]), 64'd0);

      // capture key held low across a reset pulse
      key[1] = 1'b0;
      cyc(1);
      rst = 1'b1;
      cyc(3);
      chk("hold_rst_cnt", 64'(cnt_d[0]), 64'd0);
      rst = 1'b0;
      cyc(2);
      chk("hold_rel2_cnt", 64'(cnt_d[0]), 64'd0);
      cyc(1);
      chk("hold_rel3_cnt", 64'(cnt_d[0]), 64'd1);
      chk("hold_rel3_sat", 64'(cnt_d[1]), 64'd1);
      cyc(5);
      chk("hold_once_cnt", 64'(cnt_d[0]), 64'd1);
      key[1] = 1'b1;
      cyc(4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
